life_scan: RTL and testbench

LIFE_SCAN -- requirements
Module: life_scan

---
 rtl/life_scan.sv | 124 ++++++++++++
 tb/tb_life_scan.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/life_scan.sv
`default_nettype none
// ============================================================================
// Module   : life_scan
// Purpose  : Snapshots one Game-of-Life generation per frame_strobe and streams
//            it out row by row over a valid/ready handshake.
//            Optional macro LIFE_SCAN_STILL_DET_EN adds still-life detection.
// Revision : 1.0
// ============================================================================
module life_scan #(
  parameter int X     = 8,
  parameter int Y     = 8,
  parameter int LOG2X = 3,
  parameter int LOG2Y = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [X*Y-1:0]   data,
  input  logic             frame_strobe,
  output logic [X-1:0]     row_data,
  output logic [LOG2Y-1:0] row_idx,
  output logic             row_valid,
  input  logic             row_ready,
  output logic             row_last,
  output logic             busy,
  output logic             overrun,
  output logic [15:0]      gen_cnt,
  output logic             extinct
`ifdef LIFE_SCAN_STILL_DET_EN
  ,
  output logic             still
`endif
);

  if (((1 << LOG2X) < X) || ((1 << LOG2Y) < Y)) begin : g_param_chk
    $error("life_scan: LOG2X/LOG2Y too narrow for X/Y");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t           state, state_nxt;
  logic [LOG2Y-1:0] idx_nxt;
  logic [X*Y-1:0]   snap;
  logic             at_last;
  logic             beat;
  logic             capture;
  logic             drop;

  assign at_last = (row_idx == LOG2Y'(Y - 1));
  assign beat    = (state == SEND) && row_ready;
  // A strobe is accepted when idle or exactly on the final beat; anything else is lost.
  assign capture = frame_strobe && ((state == IDLE) || (beat && at_last));
  assign drop    = frame_strobe && !capture;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      row_idx <= '0;
    end else begin
      state   <= state_nxt;
      row_idx <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = row_idx;
    row_valid = 1'b0;
    busy      = 1'b0;
    row_last  = 1'b0;
    if (state == SEND) begin
      row_valid = 1'b1;
      busy      = 1'b1;
      row_last  = at_last;
    end
    if (capture) begin
      state_nxt = SEND;
      idx_nxt   = '0;
    end else if (beat) begin
      if (at_last) state_nxt = IDLE;
      else         idx_nxt   = row_idx + 1'b1;
    end
  end

  assign row_data = row_valid ? snap[X*int'(row_idx) +: X] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap    <= '0;
      gen_cnt <= '0;
      extinct <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (capture) begin
        snap    <= data;
        gen_cnt <= gen_cnt + 16'd1;
        extinct <= (data == '0);
      end
      if (drop) overrun <= 1'b1;
    end
  end

`ifdef LIFE_SCAN_STILL_DET_EN
  logic [X*Y-1:0] prev_snap;
  logic           have_prev;

  // have_prev keeps an all-zero first capture from matching the reset value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_snap <= '0;
      have_prev <= 1'b0;
      still     <= 1'b0;
    end else if (capture) begin
      prev_snap <= data;
      have_prev <= 1'b1;
      still     <= have_prev && (data == prev_snap);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_life_scan.sv
`default_nettype none
// ============================================================================
// Module   : tb_life_scan
// Purpose  : Directed vector bench for life_scan (8x8 grid plus 8x1 wrap copy).
// Revision : 1.0
// ============================================================================
module tb_life_scan;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] data = '0;
  logic        frame_strobe = 1'b0;
  logic        row_ready = 1'b0;
  logic [7:0]  row_data;
  logic [2:0]  row_idx;
  logic        row_valid, row_last, busy, overrun, extinct;
  logic [15:0] gen_cnt;
`ifdef LIFE_SCAN_STILL_DET_EN
  logic        still;
  logic        w_still;
`endif

  logic [7:0]  w_data = '0;
  logic        w_strobe = 1'b0;
  logic        w_ready = 1'b1;
  logic [7:0]  w_row_data;
  logic [0:0]  w_row_idx;
  logic        w_row_valid, w_row_last, w_busy, w_overrun, w_extinct;
  logic [15:0] w_gen_cnt;

  life_scan #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3)) u_dut (
    .clk(clk), .rst(rst), .data(data), .frame_strobe(frame_strobe),
    .row_data(row_data), .row_idx(row_idx), .row_valid(row_valid),
    .row_ready(row_ready), .row_last(row_last), .busy(busy),
    .overrun(overrun), .gen_cnt(gen_cnt), .extinct(extinct)
`ifdef LIFE_SCAN_STILL_DET_EN
    , .still(still)
`endif
  );

  // Single-row grid: one capture per cycle makes the 16-bit wrap reachable.
  life_scan #(.X(8), .Y(1), .LOG2X(3), .LOG2Y(1)) u_wrap (
    .clk(clk), .rst(rst), .data(w_data), .frame_strobe(w_strobe),
    .row_data(w_row_data), .row_idx(w_row_idx), .row_valid(w_row_valid),
    .row_ready(w_ready), .row_last(w_row_last), .busy(w_busy),
    .overrun(w_overrun), .gen_cnt(w_gen_cnt), .extinct(w_extinct)
`ifdef LIFE_SCAN_STILL_DET_EN
    , .still(w_still)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] data;
    logic        strobe;
    logic        ready;
    logic        valid;
    logic [2:0]  idx;
    logic [7:0]  row;
    logic        last;
    logic        busy;
    logic        ovr;
    logic [15:0] gen;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [63:0] d, input logic s, input logic r, input logic v,
                     input logic [2:0] i, input logic [7:0] row, input logic l,
                     input logic b, input logic o, input logic [15:0] g);
    vec_t e;
    e.data = d; e.strobe = s; e.ready = r; e.valid = v; e.idx = i;
    e.row = row; e.last = l; e.busy = b; e.ovr = o; e.gen = g;
    vecs.push_back(e);
  endtask

  initial begin
    logic [63:0] d1, d2, d3, d4;
    d1 = 64'h0102040810204080;
    d2 = 64'hF0E1D2C3B4A59687;
    d3 = 64'h8877665544332211;
    d4 = 64'h123456789ABCDEF0;

    // Frame 1: continuous ready, data scrambled after capture.
    add(d1, 1'b1, 1'b1, 1'b1, 3'd0, d1[7:0], 1'b0, 1'b1, 1'b0, 16'd1);
    for (int k = 1; k < 8; k++)
      add(~d1, 1'b0, 1'b1, 1'b1, 3'(k), d1[8*k +: 8], (k == 7), 1'b1, 1'b0, 16'd1);
    add(~d1, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd1);
    // Frame 2: ready pattern 1,0,0 repeating.
    add(d2, 1'b1, 1'b0, 1'b1, 3'd0, d2[7:0], 1'b0, 1'b1, 1'b0, 16'd2);
    for (int b = 0; b < 7; b++) begin
      for (int r = 0; r < 3; r++)
        add('0, 1'b0, (r == 0), 1'b1, 3'(b + 1), d2[8*(b+1) +: 8], (b == 6), 1'b1, 1'b0, 16'd2);
    end
    add('0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd2);
    add('0, 1'b0, 1'b1, 1'b0, 3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 16'd2);

    // Reset state.
    repeat (2) step();
    check("rst valid", row_valid, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst last", row_last, 1'b0);
    check("rst overrun", overrun, 1'b0);
    check("rst gen", gen_cnt, 16'd0);
    check("rst extinct", extinct, 1'b0);
    check("rst idx", row_idx, 3'd0);
    check("rst row", row_data, 8'h00);
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      data = vecs[i].data;
      frame_strobe = vecs[i].strobe;
      row_ready = vecs[i].ready;
      step();
      check($sformatf("v%0d valid", i), row_valid, vecs[i].valid);
      check($sformatf("v%0d busy", i), busy, vecs[i].busy);
      check($sformatf("v%0d last", i), row_last, vecs[i].last);
      check($sformatf("v%0d overrun", i), overrun, vecs[i].ovr);
      check($sformatf("v%0d gen", i), gen_cnt, vecs[i].gen);
      if (vecs[i].valid) begin
        check($sformatf("v%0d idx", i), row_idx, vecs[i].idx);
        check($sformatf("v%0d row", i), row_data, vecs[i].row);
      end
    end
    frame_strobe = 1'b0;

    // Strobe mid-frame is dropped; strobe on the final beat chains a new frame.
    data = d3; frame_strobe = 1'b1; row_ready = 1'b1;
    step();
    frame_strobe = 1'b0; data = d4;
    repeat (3) step();
    check("ovr pre idx", row_idx, 3'd3);
    frame_strobe = 1'b1;
    step();
    frame_strobe = 1'b0;
    check("ovr set", overrun, 1'b1);
    check("ovr gen", gen_cnt, 16'd3);
    check("ovr idx", row_idx, 3'd4);
    check("ovr row", row_data, 8'h55);
    repeat (3) step();
    check("b2b pre idx", row_idx, 3'd7);
    check("b2b pre row", row_data, 8'h88);
    check("b2b pre last", row_last, 1'b1);
    frame_strobe = 1'b1;
    step();
    frame_strobe = 1'b0;
    check("b2b valid", row_valid, 1'b1);
    check("b2b idx", row_idx, 3'd0);
    check("b2b row", row_data, 8'hF0);
    check("b2b overrun", overrun, 1'b1);
    check("b2b gen", gen_cnt, 16'd4);
    repeat (8) step();
    check("b2b done busy", busy, 1'b0);

    // Extinction flag.
    data = '0; frame_strobe = 1'b1;
    step();
    frame_strobe = 1'b0;
    check("ext zero", extinct, 1'b1);
    check("ext gen", gen_cnt, 16'd5);
    repeat (8) step();
    data = 64'h1; frame_strobe = 1'b1;
    step();
    frame_strobe = 1'b0;
    check("ext one", extinct, 1'b0);
    check("ext row0", row_data, 8'h01);
    check("ovr sticky", overrun, 1'b1);

    // Asynchronous reset during a stall on row 4.
    repeat (4) step();
    row_ready = 1'b0;
    step();
    check("stall idx", row_idx, 3'd4);
    #2 rst = 1'b1;
    #1;
    check("arst valid", row_valid, 1'b0);
    check("arst busy", busy, 1'b0);
    check("arst gen", gen_cnt, 16'd0);
    check("arst overrun", overrun, 1'b0);
    check("arst extinct", extinct, 1'b0);
    data = d1; frame_strobe = 1'b1;
    step();
    frame_strobe = 1'b0; rst = 1'b0; row_ready = 1'b1;
    step();
    check("rst strobe valid", row_valid, 1'b0);
    check("rst strobe gen", gen_cnt, 16'd0);
    frame_strobe = 1'b1;
    step();
    frame_strobe = 1'b0;
    check("restart valid", row_valid, 1'b1);
    check("restart idx", row_idx, 3'd0);
    check("restart row", row_data, 8'h80);
    check("restart gen", gen_cnt, 16'd1);
    repeat (8) step();
    check("restart done", busy, 1'b0);

`ifdef LIFE_SCAN_STILL_DET_EN
    check("still first", still, 1'b0);
    frame_strobe = 1'b1;
    step();
    frame_strobe = 1'b0;
    check("still same", still, 1'b1);
    repeat (8) step();
    data = d2; frame_strobe = 1'b1;
    step();
    frame_strobe = 1'b0;
    check("still diff", still, 1'b0);
    repeat (8) step();
`endif

    // gen_cnt wrap on the single-row instance: one capture every cycle.
    check("wrap start gen", w_gen_cnt, 16'd0);
    w_data = '0; w_strobe = 1'b1;
    repeat (65535) step();
    check("wrap gen ffff", w_gen_cnt, 16'hFFFF);
    check("wrap extinct", w_extinct, 1'b1);
    check("wrap last", w_row_last, 1'b1);
    check("wrap overrun", w_overrun, 1'b0);
    step();
    check("wrap gen 0", w_gen_cnt, 16'h0000);
    w_strobe = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
